// File: rtl/alarm_mode_ctrl.sv
// Alarm clock mode controller: button-driven mode FSM, BCD alarm register with
// wrap-aware adjust, alarm match edge detection and ring auto-dismiss timer.
module alarm_mode_ctrl #(
    parameter int unsigned RING_SECS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       center,
    input  logic       sec_tick,
    input  logic [1:0] th1,
    input  logic [3:0] th2,
    input  logic [2:0] tm1,
    input  logic [3:0] tm2,
    output logic       en_run,
    output logic       en_th,
    output logic       en_tm,
    output logic       updown,
    output logic [1:0] ah1,
    output logic [3:0] ah2,
    output logic [2:0] am1,
    output logic [3:0] am2,
    output logic       disp_alarm,
    output logic [2:0] mode,
    output logic       alarm_ring
);

    typedef enum logic [2:0] {
        S_N    = 3'b000,
        S_TH   = 3'b001,
        S_TM   = 3'b010,
        S_AH   = 3'b011,
        S_AM   = 3'b100,
        S_RING = 3'b101
    } state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

    state_t     state_q, state_d;
    logic       en_run_q, en_run_d, en_th_q, en_th_d, en_tm_q, en_tm_d;
    logic       updown_q, updown_d, disp_q, disp_d, ring_q, ring_d;
    logic [1:0] ah1_q, ah1_d;
    logic [3:0] ah2_q, ah2_d;
    logic [2:0] am1_q, am1_d;
    logic [3:0] am2_q, am2_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       match_prev_q;
    logic       match, match_rise, any_btn, adj_up, adj_dn;

    function automatic logic [5:0] hour_step(input logic [1:0] tens, input logic [3:0] units,
                                             input logic inc);
        if (inc) begin
            if (tens == 2'd2 && units == 4'd3) return 6'h00;
            if (units == 4'd9) return {tens + 2'd1, 4'd0};
            return {tens, units + 4'd1};
        end
        if (tens == 2'd0 && units == 4'd0) return {2'd2, 4'd3};
        if (units == 4'd0) return {tens - 2'd1, 4'd9};
        return {tens, units - 4'd1};
    endfunction

    function automatic logic [6:0] min_step(input logic [2:0] tens, input logic [3:0] units,
                                            input logic inc);
        if (inc) begin
            if (tens == 3'd5 && units == 4'd9) return 7'h00;
            if (units == 4'd9) return {tens + 3'd1, 4'd0};
            return {tens, units + 4'd1};
        end
        if (tens == 3'd0 && units == 4'd0) return {3'd5, 4'd9};
        if (units == 4'd0) return {tens - 3'd1, 4'd9};
        return {tens, units - 4'd1};
    endfunction

    assign match      = (th1 == ah1_q) && (th2 == ah2_q) && (tm1 == am1_q) && (tm2 == am2_q);
    assign match_rise = match && !match_prev_q;
    assign any_btn    = up | down | left | right | center;
    assign adj_up     = up & ~(center | right | left);
    assign adj_dn     = down & ~(center | right | left | up);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        en_th_d    = 1'b0;
        en_tm_d    = 1'b0;
        updown_d   = updown_q;
        {ah1_d, ah2_d} = {ah1_q, ah2_q};
        {am1_d, am2_d} = {am1_q, am2_q};
        ring_cnt_d = ring_cnt_q;
        case (state_q)
            S_N: begin
                if (match_rise) begin
                    state_d    = S_RING;
                    ring_cnt_d = 8'd0;
                end else if (center) begin
                    state_d = S_TH;
                end
            end
            S_TH, S_TM, S_AH, S_AM: begin
                if (center) begin
                    state_d = S_N;
                end else if (right) begin
                    case (state_q)
                        S_TH:    state_d = S_TM;
                        S_TM:    state_d = S_AH;
                        S_AH:    state_d = S_AM;
                        default: state_d = S_TH;
                    endcase
                end else if (left) begin
                    case (state_q)
                        S_TH:    state_d = S_AM;
                        S_TM:    state_d = S_TH;
                        S_AH:    state_d = S_TM;
                        default: state_d = S_AH;
                    endcase
                end else if (adj_up || adj_dn) begin
                    case (state_q)
                        S_TH: begin
                            en_th_d  = 1'b1;
                            updown_d = adj_up;
                        end
                        S_TM: begin
                            en_tm_d  = 1'b1;
                            updown_d = adj_up;
                        end
                        S_AH:    {ah1_d, ah2_d} = hour_step(ah1_q, ah2_q, adj_up);
                        default: {am1_d, am2_d} = min_step(am1_q, am2_q, adj_up);
                    endcase
                end
            end
            S_RING: begin
                if (any_btn) begin
                    state_d = S_N;
                end else if (sec_tick) begin
                    if (ring_cnt_q >= RING_LAST) state_d = S_N;
                    else                         ring_cnt_d = ring_cnt_q + 8'd1;
                end
            end
            default: state_d = S_N;
        endcase
        // Mode-decoded outputs are registered from the next state so they align with mode.
        en_run_d = (state_d == S_N) || (state_d == S_RING);
        disp_d   = (state_d == S_AH) || (state_d == S_AM);
        ring_d   = (state_d == S_RING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_N;
            en_run_q     <= 1'b1;
            en_th_q      <= 1'b0;
            en_tm_q      <= 1'b0;
            updown_q     <= 1'b0;
            disp_q       <= 1'b0;
            ring_q       <= 1'b0;
            ah1_q        <= '0;
            ah2_q        <= '0;
            am1_q        <= '0;
            am2_q        <= '0;
            ring_cnt_q   <= '0;
            match_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            en_run_q     <= en_run_d;
            en_th_q      <= en_th_d;
            en_tm_q      <= en_tm_d;
            updown_q     <= updown_d;
            disp_q       <= disp_d;
            ring_q       <= ring_d;
            ah1_q        <= ah1_d;
            ah2_q        <= ah2_d;
            am1_q        <= am1_d;
            am2_q        <= am2_d;
            ring_cnt_q   <= ring_cnt_d;
            match_prev_q <= match;
        end
    end

    assign en_run     = en_run_q;
    assign en_th      = en_th_q;
    assign en_tm      = en_tm_q;
    assign updown     = updown_q;
    assign ah1        = ah1_q;
    assign ah2        = ah2_q;
    assign am1        = am1_q;
    assign am2        = am2_q;
    assign disp_alarm = disp_q;
    assign mode       = state_q;
    assign alarm_ring = ring_q;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Self-checking bench for alarm_mode_ctrl: directed literal checks plus random
// stimulus compared every cycle against a behavioural model in plain arithmetic.
module tb_alarm_mode_ctrl;

    localparam int RS = 3;
    localparam logic [4:0] B_C = 5'b10000, B_R = 5'b01000, B_L = 5'b00100,
                           B_U = 5'b00010, B_D = 5'b00001, B_0 = 5'b00000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0, sec_tick = 1'b0;
    int   t_hour = 0, t_min = 0;
    logic [1:0] th1, ah1;
    logic [3:0] th2, tm2, ah2, am2;
    logic [2:0] tm1, am1, mode;
    logic en_run, en_th, en_tm, updown, disp_alarm, alarm_ring;

    int errors = 0;
    int checks = 0;

    assign th1 = 2'(t_hour / 10);
    assign th2 = 4'(t_hour % 10);
    assign tm1 = 3'(t_min / 10);
    assign tm2 = 4'(t_min % 10);

    alarm_mode_ctrl #(.RING_SECS(RS)) dut (
        .clk(clk), .rst(rst),
        .up(up), .down(down), .left(left), .right(right), .center(center),
        .sec_tick(sec_tick),
        .th1(th1), .th2(th2), .tm1(tm1), .tm2(tm2),
        .en_run(en_run), .en_th(en_th), .en_tm(en_tm), .updown(updown),
        .ah1(ah1), .ah2(ah2), .am1(am1), .am2(am2),
        .disp_alarm(disp_alarm), .mode(mode), .alarm_ring(alarm_ring)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode as 0..5, alarm as plain hour/minute integers.
    int m_mode, m_ah, m_am, m_cnt;
    bit m_en_th, m_en_tm, m_updown, m_prev;

    task automatic m_reset();
        m_mode = 0; m_ah = 0; m_am = 0; m_cnt = 0;
        m_en_th = 0; m_en_tm = 0; m_updown = 0; m_prev = 1;
    endtask

    task automatic m_step();
        bit match;
        int nm, d;
        match   = (t_hour == m_ah) && (t_min == m_am);
        nm      = m_mode;
        m_en_th = 0;
        m_en_tm = 0;
        if (m_mode == 0) begin
            if (match && !m_prev) nm = 5;
            else if (center)      nm = 1;
        end else if (m_mode >= 1 && m_mode <= 4) begin
            if (center)     nm = 0;
            else if (right) nm = (m_mode % 4) + 1;
            else if (left)  nm = (m_mode == 1) ? 4 : m_mode - 1;
            else if (up || down) begin
                d = up ? 1 : -1;
                if (m_mode == 1)      begin m_en_th = 1; m_updown = up; end
                else if (m_mode == 2) begin m_en_tm = 1; m_updown = up; end
                else if (m_mode == 3) m_ah = (m_ah + d + 24) % 24;
                else                  m_am = (m_am + d + 60) % 60;
            end
        end else begin
            if (up || down || left || right || center) nm = 0;
            else if (sec_tick) begin
                m_cnt++;
                if (m_cnt >= RS) nm = 0;
            end
        end
        if (nm == 5 && m_mode != 5) m_cnt = 0;
        m_prev = match;
        m_mode = nm;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else     m_step();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_mode", 32'(mode), 32'(m_mode));
            check("cmp_ctrl", {26'd0, en_run, en_th, en_tm, updown, disp_alarm, alarm_ring},
                  {26'd0, (m_mode == 0 || m_mode == 5), m_en_th, m_en_tm, m_updown,
                   (m_mode == 3 || m_mode == 4), (m_mode == 5)});
            check("cmp_alarm", {19'd0, ah1, ah2, am1, am2},
                  {19'd0, 2'(m_ah / 10), 4'(m_ah % 10), 3'(m_am / 10), 4'(m_am % 10)});
        end
    end

    task automatic step(input logic [4:0] b, input logic tick);
        {center, right, left, up, down} = b;
        sec_tick = tick;
        @(posedge clk);
        #1;
        {center, right, left, up, down} = B_0;
        sec_tick = 1'b0;
    endtask

    task automatic settime(input int h, input int m);
        t_hour = h;
        t_min  = m;
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_ring"}, 32'(alarm_ring), 32'd0);
        check({tag, "_mode"}, 32'(mode), 32'd0);
        check({tag, "_run"}, 32'(en_run), 32'd1);
        check({tag, "_alarm"}, {19'd0, ah1, ah2, am1, am2}, 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [4:0] btn;
        int r;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_en_run", 32'(en_run), 32'd1);
        check("rst_ring", 32'(alarm_ring), 32'd0);
        check("rst_alarm", {19'd0, ah1, ah2, am1, am2}, 32'd0);
        rst = 1'b0;
        repeat (5) step(B_0, 1'b0);
        check("idle_ring", 32'(alarm_ring), 32'd0);
        check("idle_mode", 32'(mode), 32'd0);
        check("idle_run", 32'(en_run), 32'd1);

        step(B_C, 1'b0); check("to_th", 32'(mode), 32'd1); check("th_run", 32'(en_run), 32'd0);
        step(B_R, 1'b0); check("to_tm", 32'(mode), 32'd2);
        step(B_R, 1'b0); check("to_ah", 32'(mode), 32'd3); check("ah_disp", 32'(disp_alarm), 32'd1);
        repeat (3) step(B_U, 1'b0);
        check("ah_03", {26'd0, ah1, ah2}, 32'h03);
        step(B_R, 1'b0); check("to_am", 32'(mode), 32'd4);
        step(B_D, 1'b0);
        check("am_59", {25'd0, am1, am2}, 32'h59); check("am_h03", {26'd0, ah1, ah2}, 32'h03);
        step(B_C, 1'b0); check("back_n", 32'(mode), 32'd0); check("n_disp", 32'(disp_alarm), 32'd0);

        step(B_C, 1'b0);
        step(B_U, 1'b0); check("th_up", {30'd0, en_th, updown}, 32'b11);
        step(B_0, 1'b0); check("th_up_end", {30'd0, en_th, updown}, 32'b01);
        step(B_D, 1'b0); check("th_dn", {30'd0, en_th, updown}, 32'b10);
        step(B_0, 1'b0); check("th_dn_end", {30'd0, en_th, updown}, 32'b00);
        step(B_R, 1'b0);
        step(B_D, 1'b0); check("tm_dn", {29'd0, en_th, en_tm, updown}, 32'b010);
        step(B_U | B_D, 1'b0); check("tm_updn", {29'd0, en_th, en_tm, updown}, 32'b011);
        step(B_0, 1'b0); check("tm_end", 32'(en_tm), 32'd0);

        step(B_R, 1'b0);
        repeat (3) step(B_D, 1'b0);
        check("ah_00", {26'd0, ah1, ah2}, 32'h00);
        step(B_D, 1'b0); check("ah_wrap_dn", {26'd0, ah1, ah2}, 32'h23);
        step(B_U, 1'b0); check("ah_wrap_up", {26'd0, ah1, ah2}, 32'h00);
        step(B_R, 1'b0);
        step(B_U, 1'b0); check("am_wrap_up", {19'd0, ah1, ah2, am1, am2}, 32'h0000);
        step(B_D, 1'b0); check("am_wrap_dn", {19'd0, ah1, ah2, am1, am2}, {19'd0, 6'h00, 7'h59});

        repeat (31) step(B_U, 1'b0);
        step(B_L, 1'b0); check("left_ah", 32'(mode), 32'd3);
        repeat (7) step(B_U, 1'b0);
        check("alarm_0730", {19'd0, ah1, ah2, am1, am2}, {19'd0, 6'h07, 7'h30});
        step(B_C, 1'b0);

        settime(7, 29); repeat (2) step(B_0, 1'b0);
        check("pre_match", 32'(alarm_ring), 32'd0);
        settime(7, 30); step(B_0, 1'b0);
        check("ring_on", {29'd0, mode}, 32'd5); check("ring_bit", 32'(alarm_ring), 32'd1);
        step(B_C, 1'b0); check("dismiss", {28'd0, alarm_ring, mode}, 32'd0);
        repeat (5) step(B_0, 1'b0);
        check("no_rering", 32'(alarm_ring), 32'd0);

        settime(7, 31); step(B_0, 1'b0);
        settime(7, 30); step(B_0, 1'b0);
        check("ring2_on", 32'(alarm_ring), 32'd1);
        step(B_0, 1'b1); step(B_0, 1'b1);
        check("ring2_two_ticks", 32'(alarm_ring), 32'd1);
        step(B_0, 1'b1);
        check("ring2_timeout", {28'd0, alarm_ring, mode}, 32'd0);

        settime(7, 31); step(B_0, 1'b0);
        settime(7, 30); step(B_0, 1'b0);
        check("ring3_on", 32'(alarm_ring), 32'd1);
        async_reset_pulse("mid_ring_rst");

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      settime(m_ah, m_am);
            else if (r == 1) settime($urandom_range(0, 23), $urandom_range(0, 59));
            else if (r == 2) settime(m_ah, (m_am + 1) % 60);
            btn = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : B_0;
            step(btn, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) async_reset_pulse("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_mode_ctrl.md
Name: alarm_mode_ctrl

Overview:
- Mode/control stage between the debounced push-button pulses and the time counter/display path of the alarm clock.
- Runs the Normal / Set-Time-Hour / Set-Time-Minute / Set-Alarm-Hour / Set-Alarm-Minute / Ringing state machine.
- Drives run and adjust enables plus up/down direction into the time counter.
- Holds the alarm time as BCD digits, compares it against the current time, and raises the alarm output. Display mux consumes its digit-select and alarm digits.

Parameters:
- RING_SECS, 60, number of sec_tick pulses after which an unacknowledged alarm auto-dismisses (1..255).

Ports:
- clk  in  1  system clock (same divided clock that drives the time counter)
- rst  in  1  asynchronous reset, active-high
- up, down, left, right, center  in  1 each  debounced single-cycle button pulses, synchronous to clk
- sec_tick  in  1  single-cycle pulse once per second
- th1 in 2, th2 in 4, tm1 in 3, tm2 in 4  current time, BCD: hour tens, hour units, minute tens, minute units
- en_run  out  1  time counter free-run enable
- en_th  out  1  single-cycle hour adjust strobe to the time counter
- en_tm  out  1  single-cycle minute adjust strobe to the time counter
- updown  out  1  adjust direction, 1=increment, 0=decrement; valid with en_th/en_tm
- ah1 out 2, ah2 out 4, am1 out 3, am2 out 4  alarm time, BCD
- disp_alarm  out  1  1 = display shows alarm digits, 0 = current time
- mode  out  3  current state encoding
- alarm_ring  out  1  alarm active

Behaviour:
- State encodings: N=000, TH=001, TM=010, AH=011, AM=100, RING=101. Unused codes return to N on the next clk.
- Reset values (async, immediate):
  - state N, en_run=1, en_th=0, en_tm=0, updown=0.
  - Alarm register 00:00, disp_alarm=0, alarm_ring=0.
  - Ring counter 0, match_prev=1, so reset with time 00:00 does not ring.
- All outputs are registered. Every response appears on the clk edge after the input pulse (1-cycle latency).
- Button priority when several pulses share one cycle: center > right > left > up > down. Lower-priority pulses in that cycle are ignored.
- N:
  - en_run=1, disp_alarm=0.
  - center -> TH.
  - Alarm match rising edge -> RING. Match means time equals alarm (all four digits) this cycle and did not last cycle.
  - Match has priority over a same-cycle center.
- TH, TM, AH, AM (adjust states):
  - en_run=0. disp_alarm=1 in AH/AM, 0 in TH/TM.
  - right cycles TH->TM->AH->AM->TH. left cycles in reverse.
  - center -> N.
  - Alarm matches are ignored in these states. match_prev still tracks every cycle.
- Up/down adjust in TH/TM:
  - up/down gives a one-cycle en_th (TH) or en_tm (TM), with updown=1 for up and 0 for down.
  - updown holds its last value otherwise.
  - This block does not check time-counter wrap.
- Up/down adjust in AH/AM edits the internal BCD alarm registers:
  - Hour range 00..23: up at 23 -> 00, down at 00 -> 23. Units 9 carries into tens.
  - Minute range 00..59: up at 59 -> 00, down at 00 -> 59. Minute adjust never changes the hour.
  - Alarm digits are never out of range.
- RING:
  - alarm_ring=1, en_run=1, disp_alarm=0.
  - Any button pulse -> N. The dismissing pulse has no other effect.
  - Ring counter increments on sec_tick and clears on entry. When the count reaches RING_SECS -> N.
  - A button and the final tick in the same cycle -> N.
- match_prev is registered every cycle in all states. A dismissed alarm does not re-trigger within the same matching minute.
- rst asserted mid-ring or mid-adjust: immediate return to reset values. The alarm register is cleared.

Test Plan:
- Reset with time 00:00 and alarm 00:00 held 5 cycles -> alarm_ring stays 0, mode=000, en_run=1.
- center, right, right -> mode 001->010->011, en_run=0, disp_alarm=1. Then up x3 -> alarm 03:00. Then right, down -> alarm 03:59. Then center -> mode=000.
- In TH: up -> en_th=1 for exactly one cycle with updown=1. down -> en_th pulse with updown=0. In TM the same checks apply to en_tm. Simultaneous up+down -> only the up pulse.
- In AH: alarm 23:xx + up -> 00:xx. Alarm 00:xx + down -> 23:xx. In AM: xx:00 + down -> xx:59, hour unchanged.
- Alarm 07:30, time steps 07:29->07:30 in N -> alarm_ring=1 next cycle, mode=101. center pulse -> ring 0, mode 000. Time held 07:30 -> no re-ring.
- RING_SECS=3, ring triggered, 3 sec_tick pulses -> alarm_ring drops after the third. Separately, rst asserted while ringing -> alarm_ring=0 asynchronously and alarm register reads 00:00.
